// File: rtl/counter_ctrl.sv
// counter_ctrl: command-driven sequencer for a free-running up-counter.
// START/PAUSE/RESUME/STOP arrive over a valid/ready handshake. The count runs
// against a terminal value in one-shot or periodic mode, optionally prescaled
// by TICK_DIV. Completion is reported as a done pulse plus a saturating
// completed-period count.
module counter_ctrl #(
  parameter int WIDTH    = 32,
  parameter int PCNT_W   = 16,
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  limit,
  input  logic              periodic,
  output logic [WIDTH-1:0]  result,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
  output logic [PCNT_W-1:0] periods
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_PAUSE  = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_STOP   = 2'b11;

  // Prescaler needs at least one bit even when every clock is a tick.
  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [WIDTH-1:0]    limit_q, limit_d;
  logic                mode_q, mode_d;
  logic [PCNT_W-1:0]   periods_q, periods_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;

  logic accept;
  logic tick;

  assign accept = cmd_valid & ready_q;
  assign tick   = (state_q == S_RUN) && (presc_q == PRESC_LAST);

  // Next-state logic: an accepted command pre-empts any tick in the same cycle.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    periods_d = periods_q;
    presc_d   = presc_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    // Ready is withheld for the single cycle following every accept.
    ready_d   = ~accept;

    if (accept) begin
      case (cmd_op)
        OP_START: begin
          limit_d   = limit;
          mode_d    = periodic;
          result_d  = '0;
          periods_d = '0;
          presc_d   = '0;
          state_d   = S_RUN;
        end
        OP_PAUSE: begin
          if (state_q == S_RUN) state_d = S_PAUSE;
          else                  err_d   = 1'b1;
        end
        OP_RESUME: begin
          if (state_q == S_PAUSE) begin
            state_d = S_RUN;
            presc_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_STOP: begin
          state_d = S_IDLE;
        end
      endcase
    end else if (state_q == S_RUN) begin
      if (tick) begin
        presc_d = '0;
        if (result_q != limit_q) begin
          result_d = result_q + WIDTH'(1);
        end else begin
          done_d = 1'b1;
          if (periods_q != '1) periods_d = periods_q + PCNT_W'(1);
          // One-shot parks on the limit; periodic wraps to zero and keeps running.
          if (mode_q) result_d = '0;
          else        state_d  = S_DONE;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // State and output registers, cleared immediately by the async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      limit_q   <= '0;
      mode_q    <= 1'b0;
      periods_q <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      limit_q   <= limit_d;
      mode_q    <= mode_d;
      periods_q <= periods_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign result    = result_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done      = done_q;
  assign cmd_err   = err_q;
  assign periods   = periods_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: one DUT with TICK_DIV=1, one with TICK_DIV=4.
module tb_counter_ctrl;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_PAUSE  = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_STOP   = 2'b11;

  logic       clk = 1'b0;
  logic       reset;

  logic       cv, per, rdy, busy, done, err;
  logic [1:0] cop;
  logic [7:0] lim, res;
  logic [3:0] pcnt;

  logic       cv4, per4, rdy4, busy4, done4, err4;
  logic [1:0] cop4;
  logic [7:0] lim4, res4;
  logic [3:0] pcnt4;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(8), .PCNT_W(4), .TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cv), .cmd_ready(rdy), .cmd_op(cop),
    .limit(lim), .periodic(per), .result(res), .busy(busy), .done(done),
    .cmd_err(err), .periods(pcnt));

  counter_ctrl #(.WIDTH(8), .PCNT_W(4), .TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .cmd_valid(cv4), .cmd_ready(rdy4), .cmd_op(cop4),
    .limit(lim4), .periodic(per4), .result(res4), .busy(busy4), .done(done4),
    .cmd_err(err4), .periods(pcnt4));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cmd1(input logic [1:0] op, input logic [7:0] l, input logic p);
    cv = 1'b1; cop = op; lim = l; per = p;
    @(posedge clk); #1;
    cv = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cv = 1'b0; cop = OP_START; lim = '0; per = 1'b0;
    cv4 = 1'b0; cop4 = OP_START; lim4 = '0; per4 = 1'b0;
    #12;
    tests_run++; if (res !== 8'd0) begin fails++; $display("FAIL reset_result: got %0d want 0", res); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (rdy !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", rdy); end
    tests_run++; if (done !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_pulses: done %b err %b want 0 0", done, err); end
    tests_run++; if (pcnt !== 4'd0) begin fails++; $display("FAIL reset_periods: got %0d want 0", pcnt); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_oneshot();
    cmd1(OP_START, 8'd5, 1'b0);
    tests_run++; if (res !== 8'd0 || busy !== 1'b1 || rdy !== 1'b0) begin fails++; $display("FAIL oneshot_start: res %0d busy %b rdy %b want 0 1 0", res, busy, rdy); end
    for (int i = 1; i <= 5; i++) begin
      step();
      tests_run++; if (res !== 8'(i) || done !== 1'b0) begin fails++; $display("FAIL oneshot_count: res %0d done %b want %0d 0", res, done, i); end
    end
    step();
    tests_run++; if (done !== 1'b1 || res !== 8'd5) begin fails++; $display("FAIL oneshot_done: done %b res %0d want 1 5", done, res); end
    tests_run++; if (busy !== 1'b0 || pcnt !== 4'd1) begin fails++; $display("FAIL oneshot_final: busy %b periods %0d want 0 1", busy, pcnt); end
    step();
    tests_run++; if (done !== 1'b0 || res !== 8'd5) begin fails++; $display("FAIL oneshot_pulse: done %b res %0d want 0 5", done, res); end
  endtask

  task automatic test_periodic();
    cmd1(OP_START, 8'd3, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      step();
      tests_run++;
      if (res !== 8'(k % 4) || done !== ((k % 4) == 0)) begin
        fails++; $display("FAIL periodic_clk%0d: res %0d done %b want %0d %b", k, res, done, k % 4, (k % 4) == 0);
      end
    end
    tests_run++; if (pcnt !== 4'd3) begin fails++; $display("FAIL periodic_count: got %0d want 3", pcnt); end
    cmd1(OP_STOP, 8'd0, 1'b0);
    tests_run++; if (busy !== 1'b0 || res !== 8'd0 || pcnt !== 4'd3) begin fails++; $display("FAIL periodic_stop: busy %b res %0d periods %0d want 0 0 3", busy, res, pcnt); end
    step(); step();
    tests_run++; if (res !== 8'd0 || done !== 1'b0) begin fails++; $display("FAIL periodic_frozen: res %0d done %b want 0 0", res, done); end
  endtask

  task automatic test_pause_resume();
    cmd1(OP_START, 8'd10, 1'b0);
    repeat (4) step();
    tests_run++; if (res !== 8'd4) begin fails++; $display("FAIL pause_pre: res %0d want 4", res); end
    cmd1(OP_PAUSE, 8'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++; if (res !== 8'd4 || busy !== 1'b1) begin fails++; $display("FAIL pause_hold: res %0d busy %b want 4 1", res, busy); end
    end
    cmd1(OP_RESUME, 8'd0, 1'b0);
    tests_run++; if (res !== 8'd4 || err !== 1'b0) begin fails++; $display("FAIL resume_edge: res %0d err %b want 4 0", res, err); end
    // Uninterrupted done lands 11 clocks after START; paused run is 7 later (18).
    for (int i = 1; i <= 7; i++) begin
      step();
      tests_run++; if (done !== (i == 7)) begin fails++; $display("FAIL resume_done_clk%0d: done %b want %b", i, done, i == 7); end
    end
    tests_run++; if (res !== 8'd10 || pcnt !== 4'd1) begin fails++; $display("FAIL resume_final: res %0d periods %0d want 10 1", res, pcnt); end
  endtask

  task automatic test_errors();
    cmd1(OP_STOP, 8'd0, 1'b0);
    tests_run++; if (err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL stop_done: err %b busy %b want 0 0", err, busy); end
    step();
    cmd1(OP_PAUSE, 8'd0, 1'b0);
    tests_run++; if (err !== 1'b1 || busy !== 1'b0 || res !== 8'd10) begin fails++; $display("FAIL pause_idle: err %b busy %b res %0d want 1 0 10", err, busy, res); end
    step();
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL err_pulse: err %b want 0", err); end
    cmd1(OP_RESUME, 8'd0, 1'b0);
    tests_run++; if (err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL resume_idle: err %b busy %b want 1 0", err, busy); end
    step();
  endtask

  task automatic test_back_to_back();
    cv = 1'b1; cop = OP_START; lim = 8'd20; per = 1'b0;
    step();
    tests_run++; if (rdy !== 1'b0 || res !== 8'd0 || busy !== 1'b1) begin fails++; $display("FAIL b2b_first: rdy %b res %0d busy %b want 0 0 1", rdy, res, busy); end
    cop = OP_PAUSE;
    step();
    tests_run++; if (rdy !== 1'b1 || res !== 8'd1) begin fails++; $display("FAIL b2b_blocked: rdy %b res %0d want 1 1", rdy, res); end
    step();
    cv = 1'b0;
    tests_run++; if (rdy !== 1'b0 || res !== 8'd1) begin fails++; $display("FAIL b2b_second: rdy %b res %0d want 0 1", rdy, res); end
    step();
    tests_run++; if (res !== 8'd1 || busy !== 1'b1) begin fails++; $display("FAIL b2b_paused: res %0d busy %b want 1 1", res, busy); end
    cmd1(OP_STOP, 8'd0, 1'b0);
    step();
  endtask

  task automatic test_corners();
    cmd1(OP_START, 8'd0, 1'b0);
    step();
    tests_run++; if (done !== 1'b1 || res !== 8'd0 || busy !== 1'b0 || pcnt !== 4'd1) begin fails++; $display("FAIL limit0: done %b res %0d busy %b periods %0d want 1 0 0 1", done, res, busy, pcnt); end
    cmd1(OP_START, 8'd2, 1'b0);
    step(); step();
    tests_run++; if (res !== 8'd2) begin fails++; $display("FAIL stopcoin_pre: res %0d want 2", res); end
    cmd1(OP_STOP, 8'd0, 1'b0);
    tests_run++; if (done !== 1'b0 || busy !== 1'b0 || res !== 8'd2 || pcnt !== 4'd0) begin fails++; $display("FAIL stopcoin: done %b busy %b res %0d periods %0d want 0 0 2 0", done, busy, res, pcnt); end
    step();
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL stopcoin_late: done %b want 0", done); end
    cmd1(OP_START, 8'd0, 1'b1);
    repeat (20) step();
    tests_run++; if (pcnt !== 4'd15 || done !== 1'b1) begin fails++; $display("FAIL periods_sat: periods %0d done %b want 15 1", pcnt, done); end
    cmd1(OP_START, 8'd3, 1'b1);
    tests_run++; if (pcnt !== 4'd0 || res !== 8'd0 || done !== 1'b0) begin fails++; $display("FAIL restart: periods %0d res %0d done %b want 0 0 0", pcnt, res, done); end
    step();
    cmd1(OP_START, 8'd255, 1'b0);
    repeat (255) step();
    tests_run++; if (res !== 8'd255 || done !== 1'b0) begin fails++; $display("FAIL allones_max: res %0d done %b want 255 0", res, done); end
    step();
    tests_run++; if (res !== 8'd255 || done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL allones_done: res %0d done %b busy %b want 255 1 0", res, done, busy); end
  endtask

  task automatic test_tickdiv();
    cv4 = 1'b1; cop4 = OP_START; lim4 = 8'd2; per4 = 1'b0;
    step();
    cv4 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      tests_run++; if (done4 !== (i == 12)) begin fails++; $display("FAIL tickdiv_done_clk%0d: done %b want %b", i, done4, i == 12); end
      if (i == 4) begin
        tests_run++; if (res4 !== 8'd1) begin fails++; $display("FAIL tickdiv_first_tick: res %0d want 1", res4); end
      end
    end
    tests_run++; if (res4 !== 8'd2 || busy4 !== 1'b0) begin fails++; $display("FAIL tickdiv_final: res %0d busy %b want 2 0", res4, busy4); end
  endtask

  task automatic test_async_reset();
    cmd1(OP_START, 8'd1, 1'b1);
    repeat (5) step();
    tests_run++; if (res !== 8'd1 || pcnt !== 4'd2) begin fails++; $display("FAIL prereset: res %0d periods %0d want 1 2", res, pcnt); end
    #3 reset = 1'b1;
    #1;
    tests_run++; if (res !== 8'd0 || busy !== 1'b0 || pcnt !== 4'd0 || rdy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL async_reset: res %0d busy %b periods %0d rdy %b done %b want 0 0 0 1 0", res, busy, pcnt, rdy, done); end
    #1 reset = 1'b0;
    step();
    cmd1(OP_START, 8'd1, 1'b0);
    tests_run++; if (busy !== 1'b1 || res !== 8'd0) begin fails++; $display("FAIL post_reset_start: busy %b res %0d want 1 0", busy, res); end
    step();
    step();
    tests_run++; if (done !== 1'b1 || res !== 8'd1) begin fails++; $display("FAIL post_reset_done: done %b res %0d want 1 1", done, res); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause_resume();
    test_errors();
    test_back_to_back();
    test_corners();
    test_tickdiv();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
